ram_fifo_ctrl: RTL and testbench

- FIFO sequencer upstream of the single-address synchronous RAM (shared addr, separate read/write strobes, 4-bit data, 16 words).
- Turns push/pop handshakes into RAM write/read cycles, keeps pointers, count and flags, and captures RAM read data into a registered output.
- Only master of the RAM port: the RAM never sees read and write in the same cycle.

---
 rtl/ram_fifo_ctrl.sv | 127 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO sequencer driving a single-port synchronous RAM: push/pop handshakes become RAM write/read cycles.
// Optional sticky overflow/underflow flags are compiled in when RAM_FIFO_ERR_FLAG_EN is defined.
module ram_fifo_ctrl #(
  parameter int DW     = 4,
  parameter int AW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_en,
  output logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_datain,
  output logic          ram_read,
  output logic          ram_write,
  input  logic [DW-1:0] ram_dataout
`ifdef RAM_FIFO_ERR_FLAG_EN
  ,
  output logic          ovf_err,
  output logic          udf_err
`endif
);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_WAIT} state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t        state, state_next;
  logic [AW-1:0] wptr, rptr;
  logic [1:0]    lat_cnt;
  logic          push_acc, pop_acc, lat_done;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH);
  assign push_acc = wr_en && wr_ready;
  assign pop_acc  = rd_en && rd_ready;
  assign lat_done = (lat_cnt == 2'(RD_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (pop_acc) state_next = RD_ISSUE;
                else if (push_acc) state_next = WR;
      WR:       state_next = IDLE;
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT:  if (lat_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Pop wins over push; handshakes are only offered in IDLE and never during reset.
  always_comb begin
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    if (state == IDLE && !rst) begin
      rd_ready = !empty;
      wr_ready = !full && !(rd_en && !empty);
    end
  end

  // Strobes are registered from the next state, so they are high exactly during WR / RD_ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      lat_cnt    <= '0;
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
      ram_addr   <= '0;
      ram_datain <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      ram_write <= (state_next == WR);
      ram_read  <= (state_next == RD_ISSUE);
      rd_valid  <= 1'b0;
      if (push_acc) begin
        ram_addr   <= wptr;
        ram_datain <= wr_data;
        count      <= count + 1'b1;
      end
      if (pop_acc) begin
        ram_addr <= rptr;
        count    <= count - 1'b1;
      end
      if (state == WR) wptr <= wptr + 1'b1;
      if (state == RD_ISSUE) begin
        rptr    <= rptr + 1'b1;
        lat_cnt <= '0;
      end
      if (state == RD_WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
        if (lat_done) begin
          rd_data  <= ram_dataout;
          rd_valid <= 1'b1;
        end
      end
    end
  end

`ifdef RAM_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_en && full)  ovf_err <= 1'b1;
      if (rd_en && empty) udf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboarded bench for ram_fifo_ctrl with a behavioural 16x4 synchronous RAM (1-cycle read).
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [3:0] wr_data;
  logic       wr_ready, rd_ready, rd_valid, full, empty;
  logic [3:0] rd_data, ram_addr, ram_datain, ram_dataout;
  logic [4:0] count;
  logic       ram_read, ram_write;
`ifdef RAM_FIFO_ERR_FLAG_EN
  logic       ovf_err, udf_err;
`endif

  ram_fifo_ctrl #(.DW(4), .AW(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count), .ram_addr(ram_addr),
    .ram_datain(ram_datain), .ram_read(ram_read), .ram_write(ram_write),
    .ram_dataout(ram_dataout)
`ifdef RAM_FIFO_ERR_FLAG_EN
    , .ovf_err(ovf_err), .udf_err(udf_err)
`endif
  );

  always #5 clk = ~clk;

  logic [3:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_datain;
    if (ram_read)  ram_dataout <= mem[ram_addr];
  end

  int         checks = 0;
  int         errors = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_wptr, exp_rptr;
  int         exp_count;

  always @(negedge clk) begin
    if (ram_read === 1'b1 && ram_write === 1'b1) begin
      checks++; errors++;
      $display("FAIL ram_strobe_overlap: read=%b write=%b required not both", ram_read, ram_write);
    end
  end

  task automatic model_reset();
    sb.delete();
    exp_wptr = 4'h0; exp_rptr = 4'h0; exp_count = 0;
  endtask

  task automatic push(input logic [3:0] d);
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL push_ready: got %b want 1", wr_ready); end
    wr_en = 1'b1; wr_data = d;
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    sb.push_back(d); exp_count++;
    checks++; if (ram_write !== 1'b1) begin errors++; $display("FAIL push_strobe: got %b want 1", ram_write); end
    checks++; if (ram_addr !== exp_wptr) begin errors++; $display("FAIL push_addr: got %h want %h", ram_addr, exp_wptr); end
    checks++; if (ram_datain !== d) begin errors++; $display("FAIL push_data: got %h want %h", ram_datain, d); end
    checks++; if (count !== 5'(exp_count)) begin errors++; $display("FAIL push_count: got %0d want %0d", count, exp_count); end
    exp_wptr++;
  endtask

  task automatic pop();
    logic       got;
    logic [3:0] exp;
    @(negedge clk);
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL pop_ready: got %b want 1", rd_ready); end
    rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    @(negedge clk);
    exp_count--;
    checks++; if (ram_read !== 1'b1) begin errors++; $display("FAIL pop_strobe: got %b want 1", ram_read); end
    checks++; if (ram_addr !== exp_rptr) begin errors++; $display("FAIL pop_addr: got %h want %h", ram_addr, exp_rptr); end
    checks++; if (count !== 5'(exp_count)) begin errors++; $display("FAIL pop_count: got %0d want %0d", count, exp_count); end
    exp_rptr++;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) got = 1'b1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL pop_timeout: rd_valid got 0 want 1 within 8 cycles"); end
    if (got && sb.size() > 0) begin
      exp = sb.pop_front();
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL pop_data: got %h want %h", rd_data, exp); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got wr=%b rd=%b want 0 0", wr_ready, rd_ready); end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got count=%0d empty=%b full=%b want 0 1 0", count, empty, full); end
    checks++; if (rd_data !== 4'h0 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd: got data=%h valid=%b want 0 0", rd_data, rd_valid); end
    checks++; if ({ram_read, ram_write, ram_addr, ram_datain} !== 10'd0) begin errors++; $display("FAIL reset_ram: got r=%b w=%b a=%h d=%h want all 0", ram_read, ram_write, ram_addr, ram_datain); end
  endtask

  task automatic test_empty_pop();
    logic saw_ready, saw_read, saw_valid;
    saw_ready = 1'b0; saw_read = 1'b0; saw_valid = 1'b0;
    @(negedge clk); rd_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      saw_ready |= (rd_ready !== 1'b0); saw_read |= (ram_read !== 1'b0); saw_valid |= (rd_valid !== 1'b0);
    end
    rd_en = 1'b0;
    checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL empty_pop_ready: got 1 want 0"); end
    checks++; if (saw_read !== 1'b0) begin errors++; $display("FAIL empty_pop_read: got 1 want 0"); end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_valid: got 1 want 0"); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL empty_pop_count: got %0d want 0", count); end
`ifdef RAM_FIFO_ERR_FLAG_EN
    checks++; if (udf_err !== 1'b1) begin errors++; $display("FAIL udf_err: got %b want 1", udf_err); end
`endif
  endtask

  task automatic test_order();
    push(4'h4); push(4'h6); push(4'h1);
    @(negedge clk);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL order_count3: got %0d want 3", count); end
    repeat (3) pop();
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL order_valid_pulse: got %b want 0", rd_valid); end
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL order_empty: got empty=%b count=%0d want 1 0", empty, count); end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp;
    push(4'h1); push(4'h2);
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'h9;
    #1;
    checks++; if (wr_ready !== 1'b0 || rd_ready !== 1'b1) begin errors++; $display("FAIL arb_ready: got wr=%b rd=%b want 0 1", wr_ready, rd_ready); end
    @(posedge clk); #1 rd_en = 1'b0;
    @(negedge clk);
    exp_count--;
    checks++; if (ram_read !== 1'b1 || ram_write !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL arb_issue: got r=%b w=%b wr_ready=%b want 1 0 0", ram_read, ram_write, wr_ready); end
    checks++; if (ram_addr !== exp_rptr) begin errors++; $display("FAIL arb_raddr: got %h want %h", ram_addr, exp_rptr); end
    exp_rptr++;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0 || ram_write !== 1'b0) begin errors++; $display("FAIL arb_wait: got wr_ready=%b w=%b want 0 0", wr_ready, ram_write); end
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin errors++; $display("FAIL arb_return: got valid=%b data=%h want 1 %h", rd_valid, rd_data, exp); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL arb_wr_ready_after: got %b want 1", wr_ready); end
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    sb.push_back(4'h9); exp_count++;
    checks++; if (ram_write !== 1'b1 || ram_addr !== exp_wptr || ram_datain !== 4'h9) begin errors++; $display("FAIL arb_push: got w=%b a=%h d=%h want 1 %h 9", ram_write, ram_addr, ram_datain, exp_wptr); end
    checks++; if (count !== 5'(exp_count)) begin errors++; $display("FAIL arb_count: got %0d want %0d", count, exp_count); end
    exp_wptr++;
    pop(); pop();
  endtask

  task automatic test_full_wrap();
    logic saw_write;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) push(4'(i));
    @(negedge clk);
    checks++; if (count !== 5'd16 || full !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL full_flags: got count=%0d full=%b wr_ready=%b want 16 1 0", count, full, wr_ready); end
    wr_en = 1'b1; wr_data = 4'hA; saw_write = 1'b0;
    repeat (3) begin @(negedge clk); saw_write |= (ram_write !== 1'b0); end
    wr_en = 1'b0;
    checks++; if (saw_write !== 1'b0) begin errors++; $display("FAIL full_no_write: got 1 want 0"); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count_hold: got %0d want 16", count); end
`ifdef RAM_FIFO_ERR_FLAG_EN
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", ovf_err); end
`endif
    repeat (16) pop();
    push(4'hF); pop();
    push(4'h3); pop();
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    for (int i = 0; i < 8; i++) begin
      d = 4'($urandom_range(0, 15));
      push(d); pop();
    end
    for (int i = 0; i < 3; i++) push(4'($urandom_range(0, 15)));
    repeat (3) pop();
  endtask

  task automatic test_reset_mid_read();
    logic saw_valid;
    push(4'h7); pop();
    push(4'hC);
    @(negedge clk); rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL midrd_count: got count=%0d empty=%b want 0 1", count, empty); end
    checks++; if (rd_data !== 4'h0 || rd_valid !== 1'b0) begin errors++; $display("FAIL midrd_rd: got data=%h valid=%b want 0 0", rd_data, rd_valid); end
    checks++; if (rd_ready !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL midrd_idle: got rd_ready=%b wr_ready=%b want 0 1", rd_ready, wr_ready); end
    saw_valid = 1'b0;
    repeat (5) begin @(negedge clk); saw_valid |= (rd_valid !== 1'b0); end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL midrd_no_valid: got 1 want 0"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty_pop();
    test_order();
    test_arbitration();
    test_full_wrap();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
